// File: rtl/csa_slice_sequencer.sv
// Serialises a W-bit add over one external 4-bit conditional-sum adder, one slice per cycle.
// Operands are captured in IDLE; each RUN cycle picks the carry-matched slice result.
module csa_slice_sequencer #(
  parameter int N_SLICES = 4,
  localparam int W  = 4 * N_SLICES,
  localparam int IW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic [3:0]   slice_a,
  output logic [3:0]   slice_b,
  input  logic [4:0]   slice_sum0,
  input  logic [4:0]   slice_sum1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_sum, r_res;
  logic            r_carry, r_cout;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    w_a_sh, w_b_sh, w_sum_next;
  logic [4:0]      w_sel;
  logic            w_last;

  assign w_a_sh    = r_a >> {r_idx, 2'b00};
  assign w_b_sh    = r_b >> {r_idx, 2'b00};
  assign slice_a   = (r_state == RUN) ? w_a_sh[3:0] : 4'h0;
  assign slice_b   = (r_state == RUN) ? w_b_sh[3:0] : 4'h0;
  assign w_sel     = r_carry ? slice_sum1 : slice_sum0;
  assign w_last    = (r_idx == IW'(N_SLICES - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  // Result lives in its own register so it survives the accumulator clear on accept.
  assign out_sum   = r_res;
  assign out_cout  = r_cout;

  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < N_SLICES; i++)
      if (r_idx == IW'(i)) w_sum_next[4*i +: 4] = w_sel[3:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= in_a;
          r_b     <= in_b;
          r_carry <= in_cin;
          r_idx   <= '0;
          r_sum   <= '0;
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_sel[4];
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_sel[4];
            r_res  <= w_sum_next;
          end else begin
            r_idx  <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_slice_sequencer.sv
// Randomised and directed bench for csa_slice_sequencer with a behavioural slice adder.
module tb_csa_slice_sequencer;
  localparam int NS = 4;
  localparam int W  = 4 * NS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_cin = 1'b0;
  logic [3:0]   slice_a, slice_b;
  logic [4:0]   slice_sum0, slice_sum1;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;

  int tests = 0;
  int fails = 0;

  csa_slice_sequencer #(.N_SLICES(NS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .slice_a(slice_a), .slice_b(slice_b),
    .slice_sum0(slice_sum0), .slice_sum1(slice_sum1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  // External 4-bit adder: both carry-in hypotheses.
  always_comb begin
    slice_sum0 = {1'b0, slice_a} + {1'b0, slice_b};
    slice_sum1 = {1'b0, slice_a} + {1'b0, slice_b} + 5'd1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accept an op from IDLE and wait for out_valid; lat = edges after accept, -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat, output logic [W-1:0] s, output logic co);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (!out_valid) lat = -1;
    s = out_sum; co = out_cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++;
    if ({in_ready, out_valid, out_sum, out_cout, slice_a, slice_b} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0}) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b vld=%b sum=%h co=%b sa=%h sb=%h exp 1 0 0000 0 0 0",
               in_ready, out_valid, out_sum, out_cout, slice_a, slice_b);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_carry_chain();
    int lat; logic [W-1:0] s; logic co;
    out_ready = 1'b1;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, s, co);
    tests++;
    if (lat !== NS) begin fails++; $display("FAIL chain_latency got=%0d exp=%0d", lat, NS); end
    tests++;
    if ({co, s} !== 17'h10000) begin fails++; $display("FAIL chain_sum got=%b_%h exp=1_0000", co, s); end
    tick();
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL chain_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_slices();
    logic [3:0] exp_sa [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] exp_sb [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (slice_a !== exp_sa[i] || slice_b !== exp_sb[i]) begin
        fails++;
        $display("FAIL slice_seq[%0d] got a=%h b=%h exp a=%h b=%h", i, slice_a, slice_b, exp_sa[i], exp_sb[i]);
      end
      tick();
    end
    tests++;
    if (out_valid !== 1'b1 || {out_cout, out_sum} !== 17'h05556) begin
      fails++;
      $display("FAIL slices_sum got vld=%b %b_%h exp 1 0_5556", out_valid, out_cout, out_sum);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] s; logic co;
    out_ready = 1'b0;
    run_op(16'h8000, 16'h8000, 1'b1, lat, s, co);
    tests++;
    if (lat !== NS) begin fails++; $display("FAIL bp_latency got=%0d exp=%0d", lat, NS); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({out_valid, in_ready, out_cout, out_sum} !== {1'b1, 1'b0, 17'h10001}) begin
        fails++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b %b_%h exp 1 0 1_0001", i, out_valid, in_ready, out_cout, out_sum);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_run();
    int lat = 0;
    in_valid = 1'b1; in_a = 16'h0102; in_b = 16'h0304; in_cin = 1'b0;
    tick();
    in_a = 16'hFFFF; in_b = 16'hEEEE; in_cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL ignore_ready[%0d] got=%b exp=0", i, in_ready); end
      tick(); lat++;
    end
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    tests++;
    if (lat !== NS || {out_cout, out_sum} !== 17'h00406) begin
      fails++;
      $display("FAIL ignore_sum got lat=%0d %b_%h exp lat=%0d 0_0406", lat, out_cout, out_sum, NS);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [W-1:0] s; logic co;
    in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, out_sum, out_cout, slice_a, slice_b} !== {1'b1, 1'b0, 16'h0, 1'b0, 8'h0}) begin
      fails++;
      $display("FAIL midrun_reset got rdy=%b vld=%b sum=%h co=%b sa=%h sb=%h exp 1 0 0000 0 0 0",
               in_ready, out_valid, out_sum, out_cout, slice_a, slice_b);
    end
    tick();
    rst = 1'b0;
    tick();
    run_op(16'h0F0F, 16'h00F1, 1'b0, lat, s, co);
    tests++;
    if (lat !== NS || {co, s} !== 17'h01000) begin
      fails++;
      $display("FAIL after_reset got lat=%0d %b_%h exp lat=%0d 0_1000", lat, co, s, NS);
    end
    tick();
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] s, a, b; logic co, c;
    logic [W:0] exp;
    out_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      run_op(a, b, c, lat, s, co);
      tests++;
      if (lat !== NS || {co, s} !== exp) begin
        fails++;
        $display("FAIL random[%0d] a=%h b=%h c=%b got lat=%0d %b_%h exp lat=%0d %b_%h",
                 n, a, b, c, lat, co, s, NS, exp[W], exp[W-1:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_slices();
    test_backpressure();
    test_ignore_run();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
